adr_pipe_ctrl: RTL
==================

# adr_pipe_ctrl

Pipeline controller for the decode→execute boundary of the ADR core. It tracks pending register writes in a scoreboard and holds the IF and DE stages on RAW hazards, execute back-pressure, or the in-flight limit. It flushes decode on a redirect from execute and drains the pipe for fence-type instructions. It sits beside the decode stage and drives that stage's stall, flush and issue-valid qualifiers.

## Interface
- `NUM_REGS`, 32, architectural registers; x0 is hard-wired zero.
- `REG_ADDR_LEN`, 5, register address width; must equal clog2(`NUM_REGS`).
- `MAX_INFLIGHT`, 2, maximum issued-but-unretired instructions (≥1).
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `de_valid_i`  in  1  decode holds a valid instruction.
- `de_rs1_addr_i`, `de_rs2_addr_i`  in  `REG_ADDR_LEN`  source register addresses.
- `de_rs1_used_i`, `de_rs2_used_i`  in  1  the source is actually read.
- `de_rd_addr_i`  in  `REG_ADDR_LEN`  destination register address.
- `de_rd_wr_i`  in  1  the instruction writes rd.
- `de_fence_i`  in  1  the instruction requires an empty pipe before issue.
- `ex_ready_i`  in  1  execute accepts an issue this cycle.
- `ex_redirect_i`  in  1  execute resolved a taken branch or jump; younger instructions must die.
- `wb_valid_i`  in  1  one instruction retires this cycle.
- `wb_rd_wr_i`  in  1  the retiring instruction wrote a register.
- `wb_rd_addr_i`  in  `REG_ADDR_LEN`  register written by the retiring instruction.
- `if_stall_o`  out  1  fetch holds its PC and instruction.
- `de_stall_o`  out  1  decode holds its inputs.
- `de_flush_o`  out  1  decode discards its instruction.
- `de_ex_valid_o`  out  1  registered; the decode→execute payload is valid.
- `busy_o`  out  1  the in-flight count is nonzero or state ≠ RUN.
- `inflight_o`  out  clog2(`MAX_INFLIGHT`+1)  current in-flight count.

## Operation
- Scoreboard: `NUM_REGS` bits, one per register; bit 0 is never set.
- Retire clear mask: when `wb_valid_i & wb_rd_wr_i` and rd≠0, clear bit rd. The clear is visible to the hazard check in the same cycle (bypass).
- Hazard: for each used source s with addr≠0, a hazard exists when scoreboard[addr] is set and the bit is not being cleared this cycle.
- Issue condition: `issue = state==RUN & de_valid_i & ~hazard & ex_ready_i & ~ex_redirect_i & (inflight<MAX_INFLIGHT | wb_valid_i) & (~de_fence_i | inflight==0)`.
- On issue with `de_rd_wr_i` and rd≠0, set scoreboard[rd].
- Same-cycle set and clear of the same rd: the set wins, because the new writer is the youngest.
- Inflight counter: next = inflight + issue − `wb_valid_i`. A retire at inflight==0 is a protocol error; the counter saturates at 0.
- Stalls: `de_stall_o = if_stall_o = de_valid_i & ~issue & ~de_flush_o`.
- FSM states are RUN, FLUSH and DRAIN.
  - RUN→FLUSH when `ex_redirect_i` is asserted. This transition has priority in every state.
  - RUN→DRAIN when `de_valid_i & de_fence_i & inflight≠0`.
  - FLUSH→RUN after exactly one cycle. If `ex_redirect_i` is asserted again, the FSM stays in FLUSH.
  - DRAIN→RUN in the cycle where next inflight==0. The fence then issues in RUN.
- FLUSH behaviour: `de_flush_o=1`, no issue, stalls deasserted. The scoreboard is not cleared, because older in-flight writers are still valid.

## Timing
- `if_stall_o`, `de_stall_o` and `de_flush_o` are combinational from inputs and state, with zero-cycle latency.
- `de_ex_valid_o` is registered as the issue value of the previous cycle, so it is aligned with decode's registered `de_ex_*` outputs.
- `ex_redirect_i` asserted in cycle N:
  - cycle N: `de_ex_valid_o` for N+1 is 0.
  - cycle N+1: `de_flush_o`=1 (FLUSH state).
- While `reset_n` is low:
  - state=RUN, scoreboard=0, inflight=0.
  - `de_ex_valid_o`=0, `de_flush_o`=0, `busy_o`=0.
  - `if_stall_o`=`de_stall_o`=1.
- Reset asserted mid-DRAIN or mid-FLUSH returns all state to the reset values immediately, without waiting for a clock edge.

## Structure
- Shared package `ADR_define.svh` holds `REG_ADDR_LEN`, `NUM_REGS` and the enum `ADR_CTRL_STATE` {RUN, FLUSH, DRAIN}.
- Sub-module `adr_scoreboard` holds the bit vector, the set/clear/bypass logic, and the two read ports that return hazard flags.
- `adr_pipe_ctrl` holds the FSM, the inflight counter and the output logic.

## Test plan
- Back-to-back dependent instructions: issue `x5` writer, then a reader with rs1=5 and no retire → `de_stall_o`=1 each cycle. Retire `x5` → the reader issues in that same cycle, and `de_ex_valid_o`=1 in the next cycle.
- x0 rules: writer with rd=0 then reader with rs1=0 → no stall. The scoreboard stays 0.
- Same-cycle set/clear: retire `x7` while a new `x7` writer issues → scoreboard[7]=1 afterwards.
- In-flight limit (`MAX_INFLIGHT`=2):
  - Two issues without retire → third instruction stalls and `inflight_o`=2.
  - A retire in the stall cycle → the third instruction issues, and `inflight_o` stays 2.
- Redirect: `ex_redirect_i` with a valid decode → `de_ex_valid_o`=0 next cycle, `de_flush_o`=1 for one cycle, then RUN. Pending scoreboard bits are unchanged.
- Fence with inflight=2 → DRAIN. After two retires → RUN and the fence issues. Then pulse `reset_n` low mid-DRAIN → all outputs take their reset values immediately.

Source files
------------

// File: rtl/adr_pipe_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// adr_pipe_ctrl_pkg
// Shared definitions for the ADR decode->execute pipeline controller:
//   NUM_REGS      architectural register count (x0 hard-wired to zero)
//   REG_ADDR_LEN  register address width, clog2(NUM_REGS)
//   MAX_INFLIGHT  default limit on issued-but-unretired instructions
//   adr_ctrl_state_e  controller FSM states {RUN, FLUSH, DRAIN}
// -----------------------------------------------------------------------------
package adr_pipe_ctrl_pkg;

    localparam int NUM_REGS     = 32;
    localparam int REG_ADDR_LEN = 5;
    localparam int MAX_INFLIGHT = 2;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        DRAIN = 2'd2
    } adr_ctrl_state_e;

endpackage : adr_pipe_ctrl_pkg

// File: rtl/adr_pipe_ctrl_scoreboard.sv
// -----------------------------------------------------------------------------
// adr_scoreboard
// One pending-write bit per architectural register. A bit is set when an
// instruction writing that register issues and cleared when it retires.
// Two read ports report RAW hazards for the decode-stage source operands.
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   rs1_addr_i/rs1_used_i        source 1 address and "actually read" flag
//   rs2_addr_i/rs2_used_i        source 2 address and "actually read" flag
//   set_i/set_addr_i             issuing instruction writes set_addr_i
//   clr_i/clr_addr_i             retiring instruction wrote clr_addr_i
//   rs1_hazard_o/rs2_hazard_o    source operand still has a pending writer
// -----------------------------------------------------------------------------
module adr_scoreboard
    import adr_pipe_ctrl_pkg::*;
#(
    parameter int NUM_REGS_P     = NUM_REGS,
    parameter int REG_ADDR_LEN_P = REG_ADDR_LEN
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [REG_ADDR_LEN_P-1:0] rs1_addr_i,
    input  logic                      rs1_used_i,
    input  logic [REG_ADDR_LEN_P-1:0] rs2_addr_i,
    input  logic                      rs2_used_i,
    input  logic                      set_i,
    input  logic [REG_ADDR_LEN_P-1:0] set_addr_i,
    input  logic                      clr_i,
    input  logic [REG_ADDR_LEN_P-1:0] clr_addr_i,
    output logic                      rs1_hazard_o,
    output logic                      rs2_hazard_o
);

    logic [NUM_REGS_P-1:0] sb_q;
    logic [NUM_REGS_P-1:0] sb_d;
    logic [NUM_REGS_P-1:0] clr_mask;
    logic [NUM_REGS_P-1:0] set_mask;

    // Masks are built per bit so the clear path (feeding the hazard check)
    // and the set path (fed by issue, which depends on the hazard) stay in
    // separate logic cones with no apparent combinational loop.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS_P; gi++) begin : g_bit
            if (gi == 0) begin : g_x0
                // x0 never has a pending writer.
                assign clr_mask[gi] = 1'b0;
                assign set_mask[gi] = 1'b0;
                assign sb_d[gi]     = 1'b0;
            end else begin : g_xn
                assign clr_mask[gi] = clr_i & (clr_addr_i == REG_ADDR_LEN_P'(gi));
                assign set_mask[gi] = set_i & (set_addr_i == REG_ADDR_LEN_P'(gi));
                // Set wins over clear: the new writer is the youngest.
                assign sb_d[gi]     = (sb_q[gi] & ~clr_mask[gi]) | set_mask[gi];
            end
        end
    endgenerate

    // A retire in this cycle bypasses into the hazard check.
    assign rs1_hazard_o = rs1_used_i & (rs1_addr_i != '0)
                        & sb_q[rs1_addr_i] & ~clr_mask[rs1_addr_i];
    assign rs2_hazard_o = rs2_used_i & (rs2_addr_i != '0)
                        & sb_q[rs2_addr_i] & ~clr_mask[rs2_addr_i];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sb_q <= '0;
        end else begin
            sb_q <= sb_d;
        end
    end

endmodule : adr_scoreboard

// File: rtl/adr_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// adr_pipe_ctrl
// Decode->execute pipeline controller. Holds IF/DE on RAW hazards, execute
// back-pressure or the in-flight limit; flushes decode after a redirect;
// drains the pipe before a fence issues.
//
// Ports:
//   clk, reset_n                      clock, asynchronous active-low reset
//   de_valid_i                        decode holds a valid instruction
//   de_rs{1,2}_addr_i/_used_i         source operands
//   de_rd_addr_i/de_rd_wr_i           destination operand
//   de_fence_i                        instruction needs an empty pipe
//   ex_ready_i                        execute accepts an issue
//   ex_redirect_i                     execute redirects; younger ops die
//   wb_valid_i/wb_rd_wr_i/wb_rd_addr_i  retire port
//   if_stall_o/de_stall_o             hold fetch / decode
//   de_flush_o                        decode discards its instruction
//   de_ex_valid_o                     registered issue (payload valid)
//   busy_o                            work in flight or not in RUN
//   inflight_o                        issued-but-unretired count
// -----------------------------------------------------------------------------
module adr_pipe_ctrl
    import adr_pipe_ctrl_pkg::*;
#(
    parameter int NUM_REGS_P     = NUM_REGS,
    parameter int REG_ADDR_LEN_P = REG_ADDR_LEN,
    parameter int MAX_INFLIGHT_P = MAX_INFLIGHT,
    parameter int INF_W          = $clog2(MAX_INFLIGHT_P + 1)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      de_valid_i,
    input  logic [REG_ADDR_LEN_P-1:0] de_rs1_addr_i,
    input  logic [REG_ADDR_LEN_P-1:0] de_rs2_addr_i,
    input  logic                      de_rs1_used_i,
    input  logic                      de_rs2_used_i,
    input  logic [REG_ADDR_LEN_P-1:0] de_rd_addr_i,
    input  logic                      de_rd_wr_i,
    input  logic                      de_fence_i,
    input  logic                      ex_ready_i,
    input  logic                      ex_redirect_i,
    input  logic                      wb_valid_i,
    input  logic                      wb_rd_wr_i,
    input  logic [REG_ADDR_LEN_P-1:0] wb_rd_addr_i,
    output logic                      if_stall_o,
    output logic                      de_stall_o,
    output logic                      de_flush_o,
    output logic                      de_ex_valid_o,
    output logic                      busy_o,
    output logic [INF_W-1:0]          inflight_o
);

    localparam logic [INF_W-1:0] MAX_CNT = INF_W'(MAX_INFLIGHT_P);

    adr_ctrl_state_e  state_q, state_d;
    logic [INF_W-1:0] inflight_q, inflight_d;
    logic             de_ex_valid_q, de_ex_valid_d;

    logic rs1_hazard, rs2_hazard, hazard;
    logic issue;
    logic stall;

    adr_scoreboard #(
        .NUM_REGS_P     (NUM_REGS_P),
        .REG_ADDR_LEN_P (REG_ADDR_LEN_P)
    ) u_scoreboard (
        .clk          (clk),
        .reset_n      (reset_n),
        .rs1_addr_i   (de_rs1_addr_i),
        .rs1_used_i   (de_rs1_used_i),
        .rs2_addr_i   (de_rs2_addr_i),
        .rs2_used_i   (de_rs2_used_i),
        .set_i        (issue & de_rd_wr_i),
        .set_addr_i   (de_rd_addr_i),
        .clr_i        (wb_valid_i & wb_rd_wr_i),
        .clr_addr_i   (wb_rd_addr_i),
        .rs1_hazard_o (rs1_hazard),
        .rs2_hazard_o (rs2_hazard)
    );

    assign hazard = rs1_hazard | rs2_hazard;

    // A retire in the same cycle frees a slot, so issue at the limit is
    // allowed when wb_valid_i is high.
    assign issue = (state_q == RUN) & de_valid_i & ~hazard & ex_ready_i
                 & ~ex_redirect_i
                 & ((inflight_q < MAX_CNT) | wb_valid_i)
                 & (~de_fence_i | (inflight_q == '0));

    always_comb begin
        inflight_d = inflight_q;
        case ({issue, wb_valid_i})
            2'b10:   inflight_d = inflight_q + 1'b1;
            // Retire with nothing in flight is a protocol error; hold at 0.
            2'b01:   inflight_d = (inflight_q == '0) ? '0 : inflight_q - 1'b1;
            default: inflight_d = inflight_q;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        de_ex_valid_d = issue;
        case (state_q)
            RUN: begin
                if (ex_redirect_i) begin
                    state_d = FLUSH;
                end else if (de_valid_i & de_fence_i & (inflight_q != '0)) begin
                    state_d = DRAIN;
                end
            end
            FLUSH: begin
                if (!ex_redirect_i) begin
                    state_d = RUN;
                end
            end
            DRAIN: begin
                if (ex_redirect_i) begin
                    state_d = FLUSH;
                end else if (inflight_d == '0) begin
                    // The fence itself issues from RUN next cycle.
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= RUN;
            inflight_q    <= '0;
            de_ex_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            inflight_q    <= inflight_d;
            de_ex_valid_q <= de_ex_valid_d;
        end
    end

    assign de_flush_o    = (state_q == FLUSH);
    assign stall         = de_valid_i & ~issue & ~de_flush_o;
    // Fetch and decode are held for the whole reset period.
    assign if_stall_o    = ~reset_n | stall;
    assign de_stall_o    = ~reset_n | stall;
    assign de_ex_valid_o = de_ex_valid_q;
    assign busy_o        = (inflight_q != '0) | (state_q != RUN);
    assign inflight_o    = inflight_q;

endmodule : adr_pipe_ctrl
